// File: rtl/regfile_mp.sv
// Multi-port integer register file with a per-register busy scoreboard.
// Register 0 reads zero and is never busy; on write conflicts the higher-indexed port wins.
module regfile_mp_rd #(
  parameter int XLEN = 32, AW = 5, NWR = 2, BYPASS = 1
) (
  input  logic [AW-1:0]       i_ra,
  input  logic                i_ok,
  input  logic [XLEN-1:0]     i_q,
  input  logic                i_busy,
  input  logic [NWR-1:0]      i_wq,
  input  logic [NWR*AW-1:0]   i_wa,
  input  logic [NWR*XLEN-1:0] i_wd,
  input  logic                i_alloc_en,
  input  logic [AW-1:0]       i_alloc_a,
  output logic [XLEN-1:0]     o_rd,
  output logic                o_rbusy
);
  logic            w_hit;
  logic [XLEN-1:0] w_byp;

  // Later ports overwrite earlier matches, giving the highest index priority.
  always_comb begin
    w_hit = 1'b0;
    w_byp = '0;
    for (int j = 0; j < NWR; j++)
      if (i_wq[j] && i_wa[j*AW +: AW] == i_ra) begin
        w_hit = 1'b1;
        w_byp = i_wd[j*XLEN +: XLEN];
      end
  end

  always_comb begin
    o_rd    = '0;
    o_rbusy = 1'b0;
    if (i_ok) begin
      o_rd    = (BYPASS != 0 && w_hit) ? w_byp : i_q;
      o_rbusy = (BYPASS != 0 && w_hit && !(i_alloc_en && i_alloc_a == i_ra)) ? 1'b0 : i_busy;
    end
  end
endmodule

module regfile_mp #(
  parameter int XLEN = 32, NREG = 32, NRD = 3, NWR = 2, BYPASS = 1,
  localparam int AW = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NRD*AW-1:0]   ra,
  output logic [NRD*XLEN-1:0] rd,
  output logic [NRD-1:0]      rbusy,
  input  logic [NWR-1:0]      we,
  input  logic [NWR*AW-1:0]   wa,
  input  logic [NWR*XLEN-1:0] wd,
  input  logic                alloc_en,
  input  logic [AW-1:0]       alloc_a,
  output logic [NREG-1:0]     busy_vec
);
  localparam logic [AW:0] NREG_W = (AW+1)'(NREG);

  logic [XLEN-1:0] r_mem [NREG];
  logic [NREG-1:1] r_busy, w_busy_nxt;
  logic [NREG-1:0] w_busy;
  logic [NWR-1:0]  w_wq;

  always_comb begin
    w_wq = '0;
    for (int j = 0; j < NWR; j++)
      w_wq[j] = we[j] && (wa[j*AW +: AW] != '0) && ({1'b0, wa[j*AW +: AW]} < NREG_W);
  end

  // Alloc is applied after writeback so a same-cycle alloc keeps the register busy.
  always_comb begin
    w_busy_nxt = r_busy;
    for (int j = 0; j < NWR; j++)
      if (w_wq[j]) w_busy_nxt[wa[j*AW +: AW]] = 1'b0;
    if (alloc_en && alloc_a != '0 && {1'b0, alloc_a} < NREG_W)
      w_busy_nxt[alloc_a] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NREG; r++) r_mem[r] <= '0;
      r_busy <= '0;
    end else begin
      for (int j = 0; j < NWR; j++)
        if (w_wq[j]) r_mem[wa[j*AW +: AW]] <= wd[j*XLEN +: XLEN];
      r_busy <= w_busy_nxt;
    end
  end

  assign w_busy   = {r_busy, 1'b0};
  assign busy_vec = w_busy;

  for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
    logic [AW-1:0] w_ra;
    logic          w_ok;
    assign w_ra = ra[gi*AW +: AW];
    assign w_ok = (w_ra != '0) && ({1'b0, w_ra} < NREG_W);
    regfile_mp_rd #(.XLEN(XLEN), .AW(AW), .NWR(NWR), .BYPASS(BYPASS)) u_rd (
      .i_ra(w_ra), .i_ok(w_ok), .i_q(r_mem[w_ra]), .i_busy(w_busy[w_ra]),
      .i_wq(w_wq), .i_wa(wa), .i_wd(wd), .i_alloc_en(alloc_en), .i_alloc_a(alloc_a),
      .o_rd(rd[gi*XLEN +: XLEN]), .o_rbusy(rbusy[gi])
    );
  end
endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: directed vectors on a (32,32,3,2,1) instance plus a shared
// random phase against an array model for that instance and a (64,16,2,1,0) instance.
module tb_regfile_mp;
  localparam int AX = 32, AN = 32, AR = 3, AWR = 2, AB = 1, AAW = 5;
  localparam int BX = 64, BN = 16, BR = 2, BWR = 1, BB = 0, BAW = 4;
  localparam int NREG_M [2] = '{AN, BN};
  localparam int NRD_M  [2] = '{AR, BR};
  localparam int NWR_M  [2] = '{AWR, BWR};
  localparam int BYP_M  [2] = '{AB, BB};

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Bench-side stimulus, one row per instance.
  logic [5:0]  t_ra [2][6];
  logic        t_we [2][4];
  logic [5:0]  t_wa [2][4];
  logic [63:0] t_wd [2][4];
  logic        t_ae [2];
  logic [5:0]  t_aa [2];

  logic [AR*AAW-1:0] a_ra;  logic [AR*AX-1:0] a_rd;  logic [AR-1:0] a_rbusy;
  logic [AWR-1:0] a_we;     logic [AWR*AAW-1:0] a_wa; logic [AWR*AX-1:0] a_wd;
  logic a_ae;               logic [AAW-1:0] a_aa;    logic [AN-1:0] a_bv;
  logic [BR*BAW-1:0] b_ra;  logic [BR*BX-1:0] b_rd;  logic [BR-1:0] b_rbusy;
  logic [BWR-1:0] b_we;     logic [BWR*BAW-1:0] b_wa; logic [BWR*BX-1:0] b_wd;
  logic b_ae;               logic [BAW-1:0] b_aa;    logic [BN-1:0] b_bv;

  always_comb begin
    a_ra = '0; a_we = '0; a_wa = '0; a_wd = '0;
    b_ra = '0; b_we = '0; b_wa = '0; b_wd = '0;
    for (int i = 0; i < AR; i++) a_ra[i*AAW +: AAW] = t_ra[0][i][AAW-1:0];
    for (int j = 0; j < AWR; j++) begin
      a_we[j] = t_we[0][j];
      a_wa[j*AAW +: AAW] = t_wa[0][j][AAW-1:0];
      a_wd[j*AX +: AX] = t_wd[0][j][AX-1:0];
    end
    for (int i = 0; i < BR; i++) b_ra[i*BAW +: BAW] = t_ra[1][i][BAW-1:0];
    for (int j = 0; j < BWR; j++) begin
      b_we[j] = t_we[1][j];
      b_wa[j*BAW +: BAW] = t_wa[1][j][BAW-1:0];
      b_wd[j*BX +: BX] = t_wd[1][j];
    end
    a_ae = t_ae[0]; a_aa = t_aa[0][AAW-1:0];
    b_ae = t_ae[1]; b_aa = t_aa[1][BAW-1:0];
  end

  regfile_mp #(.XLEN(AX), .NREG(AN), .NRD(AR), .NWR(AWR), .BYPASS(AB)) u_a (
    .clk(clk), .reset(reset), .ra(a_ra), .rd(a_rd), .rbusy(a_rbusy), .we(a_we),
    .wa(a_wa), .wd(a_wd), .alloc_en(a_ae), .alloc_a(a_aa), .busy_vec(a_bv));
  regfile_mp #(.XLEN(BX), .NREG(BN), .NRD(BR), .NWR(BWR), .BYPASS(BB)) u_b (
    .clk(clk), .reset(reset), .ra(b_ra), .rd(b_rd), .rbusy(b_rbusy), .we(b_we),
    .wa(b_wa), .wd(b_wd), .alloc_en(b_ae), .alloc_a(b_aa), .busy_vec(b_bv));

  int n_chk = 0, n_fail = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: architectural contents and busy flags per register.
  logic [63:0] m_mem  [2][64];
  bit          m_busy [2][64];
  logic [63:0] md;

  // Final value written to register r this cycle, if any port qualifies.
  function automatic bit wr_hit(int k, int r, output logic [63:0] d);
    bit h = 1'b0;
    d = '0;
    for (int j = 0; j < NWR_M[k]; j++)
      if (t_we[k][j] && int'(t_wa[k][j]) == r && r != 0 && r < NREG_M[k]) begin
        h = 1'b1;
        d = t_wd[k][j];
      end
    return h;
  endfunction

  function automatic logic [63:0] exp_rd(int k, int i);
    int a = int'(t_ra[k][i]);
    logic [63:0] d;
    if (a == 0 || a >= NREG_M[k]) return '0;
    if (BYP_M[k] != 0 && wr_hit(k, a, d)) return d;
    return m_mem[k][a];
  endfunction

  function automatic logic [63:0] exp_rbusy(int k, int i);
    int a = int'(t_ra[k][i]);
    logic [63:0] d;
    if (a == 0 || a >= NREG_M[k]) return '0;
    if (BYP_M[k] != 0 && wr_hit(k, a, d) && !(t_ae[k] && int'(t_aa[k]) == a)) return '0;
    return 64'(m_busy[k][a]);
  endfunction

  function automatic logic [63:0] exp_bv(int k);
    logic [63:0] v = '0;
    for (int r = 0; r < NREG_M[k]; r++) v[r] = m_busy[k][r];
    return v;
  endfunction

  always @(posedge clk)
    for (int k = 0; k < 2; k++)
      if (reset) begin
        for (int r = 0; r < 64; r++) begin m_mem[k][r] = '0; m_busy[k][r] = 1'b0; end
      end else begin
        for (int r = 1; r < NREG_M[k]; r++) begin
          if (wr_hit(k, r, md)) begin m_mem[k][r] = md; m_busy[k][r] = 1'b0; end
          if (t_ae[k] && int'(t_aa[k]) == r) m_busy[k][r] = 1'b1;
        end
      end

  always @(negedge clk)
    if (chk_en) begin
      for (int i = 0; i < AR; i++) begin
        chk("A_rd", {32'h0, a_rd[i*AX +: AX]}, exp_rd(0, i));
        chk("A_rbusy", 64'(a_rbusy[i]), exp_rbusy(0, i));
      end
      chk("A_busy_vec", 64'(a_bv), exp_bv(0));
      for (int i = 0; i < BR; i++) begin
        chk("B_rd", b_rd[i*BX +: BX], exp_rd(1, i));
        chk("B_rbusy", 64'(b_rbusy[i]), exp_rbusy(1, i));
      end
      chk("B_busy_vec", 64'(b_bv), exp_bv(1));
    end

  task automatic idle();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 6; i++) t_ra[k][i] = '0;
      for (int j = 0; j < 4; j++) begin t_we[k][j] = 1'b0; t_wa[k][j] = '0; t_wd[k][j] = '0; end
      t_ae[k] = 1'b0; t_aa[k] = '0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int j, input int a, input logic [31:0] d);
    t_we[0][j] = 1'b1; t_wa[0][j] = 6'(a); t_wd[0][j] = {32'h0, d};
  endtask

  function automatic logic [63:0] ard(int i);
    return {32'h0, a_rd[i*AX +: AX]};
  endfunction

  function automatic logic [5:0] raddr(int k);
    if ($urandom_range(0, 1) == 0) return 6'($urandom_range(0, 7));
    return 6'($urandom_range(0, NREG_M[k] - 1));
  endfunction

  initial begin
    idle();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    chk_en = 1'b1;

    for (int a = 1; a < AN; a++) begin
      for (int i = 0; i < AR; i++) t_ra[0][i] = 6'(a);
      #1;
      for (int i = 0; i < AR; i++) begin
        chk("rst_rd", ard(i), 64'h0);
        chk("rst_rbusy", 64'(a_rbusy[i]), 64'h0);
      end
      chk("rst_busy_vec", 64'(a_bv), 64'h0);
      tick();
    end

    idle(); wr(0, 1, 32'hABCD1234); t_ra[0][0] = 6'd1; #1;
    chk("wr1_bypass", ard(0), 64'hABCD1234);
    tick();
    idle(); wr(0, 0, 32'hDEADBEEF); t_ra[0][0] = 6'd1; #1;
    chk("wr1_array", ard(0), 64'hABCD1234);
    chk("r0_write_cycle", ard(1), 64'h0);
    tick();
    idle(); t_ra[0][1] = 6'd1; #1;
    chk("r0_reads_zero", ard(0), 64'h0);
    chk("r1_kept", ard(1), 64'hABCD1234);
    tick();

    idle(); wr(0, 5, 32'h11111111); wr(1, 5, 32'h22222222); t_ra[0][2] = 6'd5; #1;
    chk("collide_bypass", ard(2), 64'h22222222);
    tick();
    idle(); t_ra[0][2] = 6'd5; #1;
    chk("collide_array", ard(2), 64'h22222222);
    tick();

    idle(); t_ae[0] = 1'b1; t_aa[0] = 6'd7; t_ra[0][0] = 6'd7; #1;
    chk("alloc_not_yet", 64'(a_rbusy[0]), 64'h0);
    tick();
    idle(); wr(0, 7, 32'h12345678); t_ra[0][0] = 6'd7; #1;
    chk("alloc_busy_vec", 64'(a_bv), 64'h80);
    chk("wb_rbusy_forced", 64'(a_rbusy[0]), 64'h0);
    chk("wb_rd_bypass", ard(0), 64'h12345678);
    tick();
    idle(); t_ra[0][0] = 6'd7; #1;
    chk("wb_cleared", 64'(a_bv), 64'h0);
    chk("wb_data", ard(0), 64'h12345678);
    t_ae[0] = 1'b1; t_aa[0] = 6'd7; wr(0, 7, 32'h12345678); #1;
    chk("alloc_wr_rbusy_raw", 64'(a_rbusy[0]), 64'h0);
    tick();
    idle(); t_ae[0] = 1'b1; t_aa[0] = 6'd7; wr(0, 7, 32'h5A5A5A5A); t_ra[0][0] = 6'd7; #1;
    chk("alloc_wr_busy_vec", 64'(a_bv), 64'h80);
    chk("alloc_wr_rbusy", 64'(a_rbusy[0]), 64'h1);
    chk("alloc_wr_bypass", ard(0), 64'h5A5A5A5A);
    tick();
    idle(); t_ra[0][0] = 6'd7; #1;
    chk("busy_stays", 64'(a_bv), 64'h80);
    chk("busy_stays_rd", ard(0), 64'h5A5A5A5A);
    tick();

    idle(); t_ae[0] = 1'b1; t_aa[0] = 6'd3; wr(0, 4, 32'hCAFEF00D); tick();
    idle(); t_ra[0][0] = 6'd4; t_ra[0][1] = 6'd3; #1;
    chk("pre_rst_vec", 64'(a_bv), 64'h88);
    chk("pre_rst_rd4", ard(0), 64'hCAFEF00D);
    chk("pre_rst_rbusy3", 64'(a_rbusy[1]), 64'h1);
    reset = 1'b1; wr(0, 4, 32'h0BADBEEF);
    tick();
    reset = 1'b0; idle(); t_ra[0][0] = 6'd4; t_ra[0][1] = 6'd3; #1;
    chk("post_rst_rd4", ard(0), 64'h0);
    chk("post_rst_rd3", ard(1), 64'h0);
    chk("post_rst_rbusy3", 64'(a_rbusy[1]), 64'h0);
    chk("post_rst_vec", 64'(a_bv), 64'h0);
    tick();

    for (int c = 0; c < 2000; c++) begin
      idle();
      reset = ($urandom_range(0, 199) == 0);
      for (int k = 0; k < 2; k++) begin
        for (int j = 0; j < NWR_M[k]; j++) begin
          t_we[k][j] = 1'($urandom_range(0, 1));
          t_wa[k][j] = raddr(k);
          t_wd[k][j] = {(k == 0) ? 32'h0 : $urandom(), $urandom()};
        end
        t_ae[k] = ($urandom_range(0, 3) == 0);
        t_aa[k] = raddr(k);
        for (int i = 0; i < NRD_M[k]; i++) t_ra[k][i] = raddr(k);
      end
      tick();
    end
    reset = 1'b0;
    idle();
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port integer register file with a per-register busy scoreboard, the successor to the single-write, dual-read `regfile` in the RISC-V core. It serves pipelined and dual-issue configurations: NRD combinational read ports, NWR clocked write ports with fixed priority, optional same-cycle write-to-read bypass, and busy bits set at issue and cleared at writeback for hazard detection. Register 0 is hardwired to zero and is never busy.

## Interface
- XLEN, 32: data width in bits.
- NREG, 32: number of architectural registers, 2..64.
- NRD, 3: number of read ports, 1..6.
- NWR, 2: number of write ports, 1..4.
- BYPASS, 1: 1 = write-first (reads see same-cycle write data); 0 = read-before-write.
- AW (localparam) = $clog2(NREG).

Ports (port i of a packed bus occupies [i*W +: W]):
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- ra  in  NRD*AW  read addresses.
- rd  out  NRD*XLEN  read data, combinational.
- rbusy  out  NRD  busy status of each read address, combinational.
- we  in  NWR  write enables.
- wa  in  NWR*AW  write addresses.
- wd  in  NWR*XLEN  write data.
- alloc_en  in  1  mark alloc_a busy (issue of an instruction with a destination).
- alloc_a  in  AW  register to mark busy.
- busy_vec  out  NREG  registered busy bits; bit 0 always 0.

## Operation
- Storage: NREG x XLEN array plus NREG busy flops. Entry 0 has no storage; it reads 0.
- Write: on rising edge, for each port j with we[j]=1, wa[j]!=0 and wa[j]<NREG, write wd[j] to wa[j]. If several enabled ports target the same address, the highest-indexed port wins.
- Read: rd[i] = 0 if ra[i]==0 or ra[i]>=NREG; otherwise array[ra[i]]. With BYPASS=1, if any qualifying write port targets ra[i] this cycle, rd[i] = that port's wd (highest index wins). With BYPASS=0, rd[i] shows the pre-edge value.
- Scoreboard, per register r!=0, next-state priority: reset -> 0; alloc_en && alloc_a==r -> 1; a qualifying write to r -> 0; else hold. Alloc of an already busy register keeps it 1 (no counting). Alloc of 0 or of an out-of-range address is ignored.
- rbusy[i] = busy[ra[i]]; 0 for address 0 or out of range. With BYPASS=1, rbusy[i] is forced 0 when a qualifying write to ra[i] occurs this cycle and alloc_a!=ra[i] or alloc_en=0. With BYPASS=0 it is the raw flop.
- Reset: on a rising edge with reset=1, all entries are cleared to 0 and all busy bits to 0. Writes and allocs presented in that cycle are discarded.

## Timing
- Reset values after the first reset edge: every rd=0, rbusy=0, busy_vec=0.
- Write latency: data is visible in the array one edge after we. With BYPASS=1 it is visible on rd in the same cycle, combinationally.
- Busy latency: busy_vec updates one edge after alloc_en or a write. rbusy follows the rules above.
- No handshake. Writes and allocs are accepted unconditionally every cycle.
- Reset mid-operation: a register busy when reset is asserted reads busy=0 and data=0 after the edge, and a write in the reset cycle is lost.
- Read ports are independent. Any number may address the same register.

## Test plan
- Reset, then read all ports at addresses 1..NREG-1 -> rd=0, rbusy=0, busy_vec=0.
- we[0]=1, wa=1, wd=32'hABCD1234 for one cycle, then ra[0]=1 -> rd[0]=ABCD1234. A write of DEADBEEF to register 0 -> ra=0 reads 0.
- Same cycle: we[0]/we[1] both to reg 5 with 11111111 / 22222222 -> reg 5 = 22222222. With BYPASS=1, ra[2]=5 in that cycle reads 22222222. With BYPASS=0 it reads the old value 0.
- alloc_en, alloc_a=7 -> next cycle busy_vec[7]=1 and rbusy=1 for ra=7. Write 12345678 to reg 7 -> busy clears after the edge (BYPASS=1: rbusy=0 in the write cycle). Alloc and write to 7 in the same cycle -> busy stays 1 and data = 12345678.
- Alloc reg 3 and write CAFEF00D to reg 4. Next cycle assert reset together with a write of 0BADBEEF to reg 4 -> after the edge reg 3 and reg 4 read 0, busy_vec=0.
- Random regression: 2000 cycles of random we/wa/wd/alloc against a reference model, with all read ports compared every cycle, for the parameter sets (32,32,3,2,1) and (64,16,2,1,0).
